// File: rtl/calc_op_sequencer.sv
// Calculator operand/operator sequencer with a registered ALU stage and result flags.
// Optional logic operators (AND/OR) are enabled by defining CALC_LOGIC_OPS_EN.
module calc_op_sequencer #(
  parameter int         W       = 8,
  parameter logic [3:0] KEY_ADD = 4'hA,
  parameter logic [3:0] KEY_SUB = 4'hB,
  parameter logic [3:0] KEY_AND = 4'hC,
  parameter logic [3:0] KEY_OR  = 4'hD,
  parameter logic [3:0] KEY_EQ  = 4'hE,
  parameter logic [3:0] KEY_CLR = 4'hF
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic [3:0]   key_val,
  input  logic         key_trig,
  input  logic [W-1:0] operand,
  input  logic         operand_ovr,
  output logic [W-1:0] opA,
  output logic [W-1:0] opB,
  output logic [1:0]   op_code,
  output logic [W-1:0] result,
  output logic         res_valid,
  output logic         carry,
  output logic         ovf,
  output logic         zero,
  output logic         neg,
  output logic         err,
  output logic [1:0]   state
);

  localparam logic [1:0] S_GET_A = 2'd0;
  localparam logic [1:0] S_GET_B = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  // armed stays low for the first cycle after reset so a key held through
  // reset release is absorbed into key_trig_q instead of firing an event.
  logic key_trig_q;
  logic armed;
  logic key_ev;

  assign key_ev = armed & key_trig & ~key_trig_q;

  logic       is_op;
  logic [1:0] op_sel;
  logic       ev_op;
  logic       ev_eq;
  logic       ev_clr;
  logic       ev_digit;

  always_comb begin
    is_op  = 1'b0;
    op_sel = 2'd0;
    if (key_val == KEY_ADD) begin
      is_op  = 1'b1;
      op_sel = 2'd0;
    end else if (key_val == KEY_SUB) begin
      is_op  = 1'b1;
      op_sel = 2'd1;
    end
`ifdef CALC_LOGIC_OPS_EN
    else if (key_val == KEY_AND) begin
      is_op  = 1'b1;
      op_sel = 2'd2;
    end else if (key_val == KEY_OR) begin
      is_op  = 1'b1;
      op_sel = 2'd3;
    end
`else
    else if (key_val == KEY_AND || key_val == KEY_OR) begin
      is_op = 1'b0;
    end
`endif
  end

  assign ev_op    = key_ev & is_op;
  assign ev_eq    = key_ev & (key_val == KEY_EQ);
  assign ev_clr   = key_ev & (key_val == KEY_CLR);
  assign ev_digit = key_ev & ~is_op & (key_val != KEY_EQ) & (key_val != KEY_CLR);

  // In SHOW a repeated equals reuses the previous result and the stored opB;
  // otherwise the live operand feeds B so the result lands on the EQ edge.
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] b_eff;
  logic         sub;
  logic [W:0]   sum;
  logic [W-1:0] alu_res;
  logic         alu_c;
  logic         alu_v;

  assign alu_a = (state == S_SHOW) ? result : opA;
  assign alu_b = (state == S_SHOW) ? opB : operand;

  always_comb begin
    sub     = (op_code == 2'd1);
    b_eff   = sub ? ~alu_b : alu_b;
    sum     = {1'b0, alu_a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    alu_res = sum[W-1:0];
    alu_c   = sum[W];
    if (sub)
      alu_v = (alu_a[W-1] != alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
    else
      alu_v = (alu_a[W-1] == alu_b[W-1]) && (alu_res[W-1] != alu_a[W-1]);
`ifdef CALC_LOGIC_OPS_EN
    if (op_code[1]) begin
      alu_res = op_code[0] ? (alu_a | alu_b) : (alu_a & alu_b);
      alu_c   = 1'b0;
      alu_v   = 1'b0;
    end
`endif
  end

  // res_valid qualifies result/carry/ovf/zero/neg; it is high exactly while in SHOW.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      key_trig_q <= 1'b0;
      armed      <= 1'b0;
      state      <= S_GET_A;
      opA        <= '0;
      opB        <= '0;
      op_code    <= 2'd0;
      result     <= '0;
      res_valid  <= 1'b0;
      carry      <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
      neg        <= 1'b0;
      err        <= 1'b0;
    end else begin
      key_trig_q <= key_trig;
      armed      <= 1'b1;
      if (ev_clr) begin
        state     <= S_GET_A;
        opA       <= '0;
        opB       <= '0;
        op_code   <= 2'd0;
        result    <= '0;
        res_valid <= 1'b0;
        carry     <= 1'b0;
        ovf       <= 1'b0;
        zero      <= 1'b0;
        neg       <= 1'b0;
        err       <= 1'b0;
      end else begin
        case (state)
          S_GET_A: begin
            if (ev_op) begin
              if (operand_ovr) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                opA     <= operand;
                op_code <= op_sel;
                state   <= S_GET_B;
              end
            end
          end
          S_GET_B: begin
            if (ev_eq) begin
              if (operand_ovr) begin
                state <= S_ERR;
                err   <= 1'b1;
              end else begin
                opB       <= operand;
                result    <= alu_res;
                carry     <= alu_c;
                ovf       <= alu_v;
                zero      <= (alu_res == '0);
                neg       <= alu_res[W-1];
                res_valid <= 1'b1;
                state     <= S_SHOW;
              end
            end else if (ev_op) begin
              op_code <= op_sel;
            end
          end
          S_SHOW: begin
            if (ev_op) begin
              opA       <= result;
              op_code   <= op_sel;
              res_valid <= 1'b0;
              state     <= S_GET_B;
            end else if (ev_digit) begin
              res_valid <= 1'b0;
              state     <= S_GET_A;
            end else if (ev_eq) begin
              opA       <= result;
              result    <= alu_res;
              carry     <= alu_c;
              ovf       <= alu_v;
              zero      <= (alu_res == '0);
              neg       <= alu_res[W-1];
              res_valid <= 1'b1;
            end
          end
          default: begin
            err       <= 1'b1;
            res_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: expected results queued at issue time,
// a negedge monitor pops and compares each time a new result is presented.
module tb_calc_op_sequencer;
  localparam int W = 8;
  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_CLR = 4'hF;

  logic         CLK;
  logic         reset;
  logic [3:0]   key_val;
  logic         key_trig;
  logic [W-1:0] operand;
  logic         operand_ovr;
  logic [W-1:0] opA;
  logic [W-1:0] opB;
  logic [1:0]   op_code;
  logic [W-1:0] result;
  logic         res_valid;
  logic         carry;
  logic         ovf;
  logic         zero;
  logic         neg;
  logic         err;
  logic [1:0]   state;

  calc_op_sequencer #(.W(W)) dut (
    .CLK(CLK), .reset(reset), .key_val(key_val), .key_trig(key_trig),
    .operand(operand), .operand_ovr(operand_ovr), .opA(opA), .opB(opB),
    .op_code(op_code), .result(result), .res_valid(res_valid), .carry(carry),
    .ovf(ovf), .zero(zero), .neg(neg), .err(err), .state(state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // packet: {opA, result, carry, ovf, zero, neg}
  logic [2*W+3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input logic [W-1:0] a, input logic [W-1:0] r,
                            input logic c, input logic v, input logic z, input logic n);
    exp_q.push_back({a, r, c, v, z, n});
  endtask

  // driver: one key press (one cycle high, one cycle low)
  task automatic press(input logic [3:0] k, input logic [W-1:0] opnd, input logic ovr);
    key_val     = k;
    operand     = opnd;
    operand_ovr = ovr;
    key_trig    = 1'b1;
    @(posedge CLK); #1;
    key_trig    = 1'b0;
    @(posedge CLK); #1;
  endtask

  // monitor / scoreboard
  logic         rv_q = 1'b0;
  logic [W-1:0] res_q = '0;
  logic [W-1:0] opa_q = '0;
  always @(negedge CLK) begin
    if (reset && res_valid && (!rv_q || result != res_q || opA != opa_q)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h with empty expected queue", result);
      end else begin
        logic [2*W+3:0] e;
        logic [2*W+3:0] a;
        e = exp_q.pop_front();
        a = {opA, result, carry, ovf, zero, neg};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL result_pkt {opA,result,c,v,z,n}: got 0x%0h, expected 0x%0h", a, e);
        end
      end
    end
    rv_q  = res_valid;
    res_q = result;
    opa_q = opA;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int changes;
    logic [1:0] prev;
    reset       = 1'b0;
    key_trig    = 1'b1;
    key_val     = K_ADD;
    operand     = 8'd5;
    operand_ovr = 1'b0;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_state", state, 0);
    check("rst_opA", opA, 0);
    check("rst_opB", opB, 0);
    check("rst_op_code", op_code, 0);
    check("rst_result", result, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_flags", {carry, ovf, zero, neg}, 0);
    check("rst_err", err, 0);
    key_trig = 1'b0;
    @(posedge CLK); #1;

    // 5 + 3
    press(K_ADD, 8'd5, 1'b0);
    check("add_getb_state", state, 1);
    check("add_opA", opA, 5);
    expect_res(8'd5, 8'd8, 0, 0, 0, 0);
    press(K_EQ, 8'd3, 1'b0);
    check("add_show_state", state, 2);
    check("add_opB", opB, 3);
    press(K_CLR, 8'd0, 1'b0);

    // 100 + 50 signed overflow
    press(K_ADD, 8'd100, 1'b0);
    expect_res(8'd100, 8'h96, 0, 1, 0, 1);
    press(K_EQ, 8'd50, 1'b0);
    press(K_CLR, 8'd0, 1'b0);

    // 3 - 5
    press(K_SUB, 8'd3, 1'b0);
    check("sub_op_code", op_code, 1);
    expect_res(8'd3, 8'hFE, 0, 0, 0, 1);
    press(K_EQ, 8'd5, 1'b0);
    press(K_CLR, 8'd0, 1'b0);

    // chaining: 5+3=8, -8=0, repeat = 0-8
    press(K_ADD, 8'd5, 1'b0);
    expect_res(8'd5, 8'd8, 0, 0, 0, 0);
    press(K_EQ, 8'd3, 1'b0);
    press(K_SUB, 8'd77, 1'b0);
    check("chain_state", state, 1);
    check("chain_opA", opA, 8);
    check("chain_res_valid", res_valid, 0);
    expect_res(8'd8, 8'd0, 1, 0, 1, 0);
    press(K_EQ, 8'd8, 1'b0);
    expect_res(8'd0, 8'hF8, 0, 0, 0, 1);
    press(K_EQ, 8'd99, 1'b0);
    check("repeat_opB", opB, 8);
    check("repeat_state", state, 2);
    press(K_CLR, 8'd0, 1'b0);

    // digit ignored in GET_A, held key gives one event
    press(4'h3, 8'd0, 1'b0);
    check("digit_geta_state", state, 0);
    key_val  = K_ADD;
    operand  = 8'd7;
    key_trig = 1'b1;
    changes  = 0;
    prev     = state;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (state != prev) changes++;
      prev = state;
    end
    key_trig = 1'b0;
    @(posedge CLK); #1;
    check("held_key_transitions", changes, 1);
    check("held_key_opA", opA, 7);
    key_val  = K_CLR;
    key_trig = 1'b1;
    @(posedge CLK); #1;
    check("clr_state", state, 0);
    check("clr_opA", opA, 0);
    key_trig = 1'b0;
    @(posedge CLK); #1;

    // digit from SHOW returns to GET_A, result held
    press(K_ADD, 8'd1, 1'b0);
    expect_res(8'd1, 8'd2, 0, 0, 0, 0);
    press(K_EQ, 8'd1, 1'b0);
    press(4'h5, 8'd0, 1'b0);
    check("show_digit_state", state, 0);
    check("show_digit_rv", res_valid, 0);
    check("show_digit_result", result, 2);
    press(K_CLR, 8'd0, 1'b0);

    // operand overflow -> ERR, sticky until clear
    press(K_ADD, 8'd5, 1'b1);
    check("err_state", state, 3);
    check("err_flag", err, 1);
    press(K_EQ, 8'd1, 1'b0);
    press(K_ADD, 8'd1, 1'b0);
    check("err_sticky_state", state, 3);
    check("err_sticky_flag", err, 1);
    check("err_res_valid", res_valid, 0);
    press(K_CLR, 8'd0, 1'b0);
    check("err_clr_state", state, 0);
    check("err_clr_flag", err, 0);

    repeat (3) @(posedge CLK);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
